// File: rtl/sram_arbiter.sv
// Two-requester arbiter and sequencer in front of a single-port SRAM.
// Requester 0 is the core, requester 1 is the host/debug loader. A granted
// command is latched, driven onto the SRAM pins for exactly one cycle, and for
// reads the SRAM data is returned to the owner after RD_LAT cycles.
module sram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LAT     = 1   // legal range 1..4
) (
  input  logic                  clk,
  input  logic                  arst,
  // Core port (requester 0)
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  // Host port (requester 1)
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  // SRAM pins
  output logic                  sram_write_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_out,
  input  logic [DATA_WIDTH-1:0] sram_data_in,
  // Status
  output logic                  busy,
  output logic                  owner
);

  // Wait counter is wide enough for the maximum legal latency of 4.
  localparam logic [2:0] LatInit = 3'(RD_LAT);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic                  r_we;
  logic                  r_owner;
  logic                  r_prio;     // requester that wins the next tie
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  r_rvalid0;
  logic                  r_rvalid1;

  logic                  w_accept;   // IDLE edge that latches a new command
  logic                  w_winner;
  logic                  w_capture;  // last WAIT edge: SRAM read data is valid
  logic                  w_issue;
  logic                  w_wait;

  assign w_issue   = (r_state == StIssue);
  assign w_wait    = (r_state == StWait);
  assign w_accept  = (r_state == StIdle) && (req0 || req1);
  assign w_capture = w_wait && (r_cnt == 3'd1);

  // Tie goes to the requester not granted last; a lone request always wins.
  assign w_winner = (req0 && req1) ? r_prio : req1;

  // Next-state logic for the IDLE -> ISSUE -> (WAIT) -> IDLE sequence.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (req0 || req1) w_state_d = StIssue;
      StIssue: w_state_d = r_we ? StIdle : StWait;
      StWait:  if (r_cnt == 3'd1) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Latch the winner's command; the address/data registers drive the SRAM pins
  // directly and so hold their value outside ISSUE.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_we    <= 1'b0;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_owner <= w_winner;
      r_prio  <= ~w_winner;
      if (w_winner) begin
        r_we    <= we1;
        r_addr  <= addr1;
        r_wdata <= wdata1;
      end else begin
        r_we    <= we0;
        r_addr  <= addr0;
        r_wdata <= wdata0;
      end
    end
  end

  // Read latency counter: loaded when a read leaves ISSUE, counts down in WAIT.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt <= 3'd0;
    end else if (w_issue && !r_we) begin
      r_cnt <= LatInit;
    end else if (w_wait) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Capture read data into the owner's register only; the other port's data is
  // left untouched.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_capture) begin
      if (r_owner) begin
        r_rdata1 <= sram_data_in;
      end else begin
        r_rdata0 <= sram_data_in;
      end
    end
  end

  // One-cycle read-valid pulse to the owner, coincident with the return to IDLE.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_capture && !r_owner;
      r_rvalid1 <= w_capture &&  r_owner;
    end
  end

  // Grants and the write strobe decode from state so they fall with arst.
  assign gnt0          = w_issue && !r_owner;
  assign gnt1          = w_issue &&  r_owner;
  assign sram_write_en = w_issue && r_we;
  assign sram_addr     = r_addr;
  assign sram_data_out = r_wdata;
  assign rvalid0       = r_rvalid0;
  assign rvalid1       = r_rvalid1;
  assign rdata0        = r_rdata0;
  assign rdata1        = r_rdata1;
  assign busy          = (r_state != StIdle);
  assign owner         = r_owner;

  // Design-intent checks.
  a_lat_range: assert property (@(posedge clk) (RD_LAT >= 1) && (RD_LAT <= 4));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (arst) !(gnt0 && gnt1));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (arst) !(rvalid0 && rvalid1));
  a_issue_once: assert property (@(posedge clk) disable iff (arst) w_issue |=> !w_issue);

endmodule
